// File: rtl/tsc_pkg.sv
// Shared types for the token sequence checker: FSM states, symbol classes,
// result encodings and reject-cause codes.
package tsc_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_STAGE, ST_ACCEPT, ST_REJECT} state_t;

  typedef enum logic [2:0] {CLS_NONE, CLS_STAGE, CLS_END_A, CLS_END_B, CLS_ABORT} sym_cls_t;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_END_A  = 2'b01;
  localparam logic [1:0] RES_END_B  = 2'b10;
  localparam logic [1:0] RES_REJECT = 2'b11;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ORDER   = 3'd1;
  localparam logic [2:0] ERR_TERM    = 3'd2;
  localparam logic [2:0] ERR_ABORT   = 3'd3;
  localparam logic [2:0] ERR_REPEAT  = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;

endpackage

// File: rtl/tsc_sym_decode.sv
// Combinational symbol classifier: terminators win over stage codes, and among
// duplicated stage codes the lowest stage index wins.
module tsc_sym_decode
  import tsc_pkg::*;
#(
  parameter int                            SYM_W       = 7,
  parameter int                            NUM_STAGES  = 5,
  parameter logic [NUM_STAGES*SYM_W-1:0]   STAGE_CODES = {7'h0C, 7'h28, 7'h4F, 7'h6B, 7'h58},
  parameter logic [SYM_W-1:0]              END_A_CODE  = 7'h32,
  parameter logic [SYM_W-1:0]              END_B_CODE  = 7'h23,
  parameter logic [SYM_W-1:0]              ABORT_CODE  = 7'h16
) (
  input  logic [SYM_W-1:0] i_sym,
  output sym_cls_t         o_cls,
  output logic [3:0]       o_idx
);

  always_comb begin
    o_cls = CLS_NONE;
    o_idx = 4'd0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (i_sym == STAGE_CODES[i*SYM_W +: SYM_W]) begin
        o_cls = CLS_STAGE;
        o_idx = 4'(i + 1);
      end
    end
    if (i_sym == ABORT_CODE) begin
      o_cls = CLS_ABORT;
      o_idx = 4'd0;
    end else if (i_sym == END_B_CODE) begin
      o_cls = CLS_END_B;
      o_idx = 4'd0;
    end else if (i_sym == END_A_CODE) begin
      o_cls = CLS_END_A;
      o_idx = 4'd0;
    end
  end

endmodule

// File: rtl/token_seq_checker.sv
// Ordered token sequence checker; stage symbols must move by at most one stage and end
// with the terminator matching the stage region. Optional idle timeout: TSC_TIMEOUT_EN.
module token_seq_checker
  import tsc_pkg::*;
#(
  parameter int                            SYM_W       = 7,
  parameter int                            NUM_STAGES  = 5,
  parameter logic [NUM_STAGES*SYM_W-1:0]   STAGE_CODES = {7'h0C, 7'h28, 7'h4F, 7'h6B, 7'h58},
  parameter logic [SYM_W-1:0]              END_A_CODE  = 7'h32,
  parameter logic [SYM_W-1:0]              END_B_CODE  = 7'h23,
  parameter logic [SYM_W-1:0]              ABORT_CODE  = 7'h16,
  parameter int                            SPLIT       = 3,
  parameter int                            MAX_REPEAT  = 15,
  parameter int                            TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  output logic [3:0]       stage_o,
  output logic             done_o,
  output logic [1:0]       result_o,
  output logic [2:0]       err_o,
  output logic [7:0]       sym_count_o
);

  localparam int REP_W = $clog2(MAX_REPEAT + 1);

  sym_cls_t         w_cls;
  logic [3:0]       w_idx;
  state_t           r_state, w_state_nxt;
  logic [3:0]       r_stage, w_stage_nxt;
  logic             r_done, w_done_nxt;
  logic [1:0]       r_result, w_result_nxt;
  logic [2:0]       r_err, w_err_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic             w_adj;

  tsc_sym_decode #(
    .SYM_W      (SYM_W),
    .NUM_STAGES (NUM_STAGES),
    .STAGE_CODES(STAGE_CODES),
    .END_A_CODE (END_A_CODE),
    .END_B_CODE (END_B_CODE),
    .ABORT_CODE (ABORT_CODE)
  ) u_decode (
    .i_sym(sym),
    .o_cls(w_cls),
    .o_idx(w_idx)
  );

`ifdef TSC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to, w_to_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

  // Widened compares so stage 15 +1 cannot wrap into an adjacency match.
  assign w_adj = (w_idx == r_stage)
              || ({1'b0, w_idx} == {1'b0, r_stage} + 5'd1)
              || ({1'b0, r_stage} == {1'b0, w_idx} + 5'd1);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_stage  <= 4'd0;
      r_done   <= 1'b0;
      r_result <= RES_NONE;
      r_err    <= ERR_NONE;
      r_cnt    <= 8'd0;
      r_rep    <= '0;
`ifdef TSC_TIMEOUT_EN
      r_to     <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_stage  <= w_stage_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rep    <= w_rep_nxt;
`ifdef TSC_TIMEOUT_EN
      r_to     <= w_to_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stage_nxt  = r_stage;
    w_done_nxt   = r_done;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    w_cnt_nxt    = r_cnt;
    w_rep_nxt    = r_rep;
`ifdef TSC_TIMEOUT_EN
    w_to_nxt     = '0;
`endif
    if (clear) begin
      w_state_nxt  = ST_IDLE;
      w_stage_nxt  = 4'd0;
      w_done_nxt   = 1'b0;
      w_result_nxt = RES_NONE;
      w_err_nxt    = ERR_NONE;
      w_cnt_nxt    = 8'd0;
      w_rep_nxt    = '0;
    end else if (sym_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_cls == CLS_STAGE) begin
            w_state_nxt = ST_STAGE;
            w_stage_nxt = w_idx;
            w_rep_nxt   = REP_W'(1);
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        ST_STAGE: begin
          case (w_cls)
            CLS_STAGE: begin
              if (!w_adj) begin
                w_state_nxt = ST_REJECT; w_result_nxt = RES_REJECT; w_err_nxt = ERR_ORDER;
              end else if (w_idx != r_stage) begin
                w_stage_nxt = w_idx;
                w_rep_nxt   = REP_W'(1);
                w_cnt_nxt   = w_cnt_inc;
              end else if (r_rep == REP_W'(MAX_REPEAT)) begin
                w_state_nxt = ST_REJECT; w_result_nxt = RES_REJECT; w_err_nxt = ERR_REPEAT;
              end else begin
                w_rep_nxt   = r_rep + REP_W'(1);
                w_cnt_nxt   = w_cnt_inc;
              end
            end
            CLS_END_A: begin
              if (r_stage <= 4'(SPLIT)) begin
                w_state_nxt = ST_ACCEPT; w_result_nxt = RES_END_A;
              end else begin
                w_state_nxt = ST_REJECT; w_result_nxt = RES_REJECT; w_err_nxt = ERR_TERM;
              end
            end
            CLS_END_B: begin
              if (r_stage > 4'(SPLIT)) begin
                w_state_nxt = ST_ACCEPT; w_result_nxt = RES_END_B;
              end else begin
                w_state_nxt = ST_REJECT; w_result_nxt = RES_REJECT; w_err_nxt = ERR_TERM;
              end
            end
            CLS_ABORT: begin
              w_state_nxt = ST_REJECT; w_result_nxt = RES_REJECT; w_err_nxt = ERR_ABORT;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
`ifdef TSC_TIMEOUT_EN
    else if (r_state == ST_STAGE) begin
      w_to_nxt = r_to + TO_W'(1);
      if (w_to_nxt == TO_W'(TIMEOUT_CYC)) begin
        w_state_nxt = ST_REJECT; w_result_nxt = RES_REJECT; w_err_nxt = ERR_TIMEOUT;
        w_to_nxt    = '0;
      end
    end
`endif
    if (w_state_nxt == ST_ACCEPT || w_state_nxt == ST_REJECT) w_done_nxt = 1'b1;
  end

  assign stage_o     = r_stage;
  assign done_o      = r_done;
  assign result_o    = r_result;
  assign err_o       = r_err;
  assign sym_count_o = r_cnt;

endmodule
